// File: rtl/regfile_param_if.sv
// Register file port bundle: decode/writeback side is master, the register file is slave.
interface regfile_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            WRITE;
  logic [AW-1:0]   inaddr_a;
  logic [AW-1:0]   inaddr_b;
  logic [AW-1:0]   inaddr_w;
  logic [XLEN-1:0] indata_w;
  logic [XLEN-1:0] outdata_a;
  logic [XLEN-1:0] outdata_b;
  logic            READY;
  logic [AW-1:0]   clr_idx;

  modport master (
    output WRITE, inaddr_a, inaddr_b, inaddr_w, indata_w,
    input  outdata_a, outdata_b, READY, clr_idx
  );

  modport slave (
    input  WRITE, inaddr_a, inaddr_b, inaddr_w, indata_w,
    output outdata_a, outdata_b, READY, clr_idx
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised RV32 integer register file, x0 hardwired to zero, sequential clear after reset.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic            CLK,
  input logic            RST,
  regfile_param_if.slave rf
);
  localparam int NREGS = 2 ** AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   idx_nxt;
  logic [XLEN-1:0] mem [NREGS];
  logic            running;
  logic            wr_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = '0;
    if (state == CLEAR) begin
      if (idx_q == LAST_IDX) begin
        state_nxt = RUN;
      end else begin
        idx_nxt = idx_q + AW'(1);
      end
    end
  end

  // Outputs are also masked while RST is held, before the state register catches up.
  assign running = (state == RUN) && !RST;
  assign wr_en   = running && rf.WRITE && (rf.inaddr_w != '0);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[idx_q] <= '0;
      end else if (wr_en) begin
        mem[rf.inaddr_w] <= rf.indata_w;
      end
    end
  end

  always_comb begin
    rf.READY     = running;
    rf.clr_idx   = idx_q;
    rf.outdata_a = '0;
    rf.outdata_b = '0;
    if (running && rf.inaddr_a != '0) begin
      rf.outdata_a = mem[rf.inaddr_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && rf.inaddr_w == rf.inaddr_a) rf.outdata_a = rf.indata_w;
`endif
    end
    if (running && rf.inaddr_b != '0) begin
      rf.outdata_b = mem[rf.inaddr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && rf.inaddr_w == rf.inaddr_b) rf.outdata_b = rf.indata_w;
`endif
    end
  end
endmodule
